// File: rtl/serial_div_arbiter.sv
// Round-robin front end that shares one serial divider between NUM_REQ requesters.
// Handles operand capture, command sequencing, divide-by-zero short-circuit and a hung-divider watchdog.
module serial_div_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DIVIDEND_WIDTH = 16,
    parameter int DIVISOR_WIDTH  = 8,
    parameter int REMINDER_WIDTH = 0,
    parameter int TIMEOUT_WIDTH  = 6
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [NUM_REQ-1:0]                        req_i,
    input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0]         dividend_i,
    input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]          divisor_i,
    output logic [NUM_REQ-1:0]                        ack_o,
    output logic [DIVIDEND_WIDTH+REMINDER_WIDTH-1:0]  quotient_o,
    output logic                                      div0_o,
    output logic                                      err_o,
    output logic [DIVIDEND_WIDTH-1:0]                 div_dividend_o,
    output logic [DIVISOR_WIDTH-1:0]                  div_divisor_o,
    output logic                                      div_cmd_o,
    input  logic                                      div_busy_i,
    input  logic                                      div_done_i,
    input  logic [DIVIDEND_WIDTH+REMINDER_WIDTH-1:0]  div_quotient_i
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                     state;
    logic [PTR_W-1:0]           ptr;
    logic [PTR_W-1:0]           grant_q;
    logic [TIMEOUT_WIDTH-1:0]   wd;
    logic                       res_div0;
    logic                       res_err;

    logic [NUM_REQ-1:0]         eligible;
    logic                       grant_valid;
    logic [PTR_W-1:0]           grant_idx;
    logic [DIVIDEND_WIDTH-1:0]  sel_dividend;
    logic [DIVISOR_WIDTH-1:0]   sel_divisor;

    // The requester being acked still holds req_i this cycle; masking it avoids a duplicate grant.
    assign eligible = req_i & ~ack_o;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!grant_valid && eligible[(int'(ptr) + i) % NUM_REQ]) begin
                grant_valid = 1'b1;
                grant_idx   = PTR_W'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

    assign sel_dividend = dividend_i[grant_idx*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
    assign sel_divisor  = divisor_i[grant_idx*DIVISOR_WIDTH +: DIVISOR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            ptr            <= PTR_W'(NUM_REQ - 1);
            grant_q        <= '0;
            wd             <= '0;
            res_div0       <= 1'b0;
            res_err        <= 1'b0;
            ack_o          <= '0;
            quotient_o     <= '0;
            div0_o         <= 1'b0;
            err_o          <= 1'b0;
            div_dividend_o <= '0;
            div_divisor_o  <= '0;
            div_cmd_o      <= 1'b0;
        end else begin
            ack_o     <= '0;
            div0_o    <= 1'b0;
            err_o     <= 1'b0;
            div_cmd_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        ptr            <= grant_idx;
                        grant_q        <= grant_idx;
                        div_dividend_o <= sel_dividend;
                        div_divisor_o  <= sel_divisor;
                        res_err        <= 1'b0;
                        if (sel_divisor == '0) begin
                            quotient_o <= '1;
                            res_div0   <= 1'b1;
                            state      <= RESP;
                        end else begin
                            res_div0   <= 1'b0;
                            state      <= ISSUE;
                        end
                    end
                end
                // A divider still finishing work from before a reset stays busy; wait it out.
                ISSUE: begin
                    if (!div_busy_i) begin
                        div_cmd_o <= 1'b1;
                        wd        <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (div_done_i) begin
                        quotient_o <= div_quotient_i;
                        state      <= RESP;
                    end else if (wd == '1) begin
                        quotient_o <= '0;
                        res_err    <= 1'b1;
                        state      <= RESP;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                RESP: begin
                    ack_o[grant_q] <= 1'b1;
                    div0_o         <= res_div0;
                    err_o          <= res_err;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_div_arbiter.sv
// Directed bench for serial_div_arbiter with a behavioural serial divider taking QW cycles per divide.
module tb_serial_div_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int VW = 8;
    localparam int QW = 16;
    localparam int TW = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req = '0;
    logic [NR*DW-1:0] dividend = '0;
    logic [NR*VW-1:0] divisor = '0;
    logic [NR-1:0]    ack;
    logic [QW-1:0]    quotient;
    logic             div0;
    logic             err;
    logic [DW-1:0]    div_dividend;
    logic [VW-1:0]    div_divisor;
    logic             div_cmd;
    logic             div_busy = 1'b0;
    logic             div_done = 1'b0;
    logic [QW-1:0]    div_quot = '0;

    int tests_run = 0;
    int tests_failed = 0;

    bit            hang = 1'b0;
    int            model_cnt = 0;
    logic [QW-1:0] model_q = '0;

    int            grant_order [8];
    logic [QW-1:0] grant_quot [8];
    int            grants_got;

    typedef struct {
        int            idx;
        logic [DW-1:0] dd;
        logic [VW-1:0] dv;
        logic [QW-1:0] exp_q;
        logic          exp_div0;
        int            exp_ack;
        int            exp_cmd;
    } vec_t;

    vec_t vecs [7];

    serial_div_arbiter #(
        .NUM_REQ(NR), .DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW),
        .REMINDER_WIDTH(0), .TIMEOUT_WIDTH(TW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req),
        .dividend_i(dividend), .divisor_i(divisor),
        .ack_o(ack), .quotient_o(quotient), .div0_o(div0), .err_o(err),
        .div_dividend_o(div_dividend), .div_divisor_o(div_divisor), .div_cmd_o(div_cmd),
        .div_busy_i(div_busy), .div_done_i(div_done), .div_quotient_i(div_quot)
    );

    always #5 clk = ~clk;

    // Divider model: command seen in cycle c gives done in cycle c+QW; it has no reset of its own.
    always @(negedge clk) begin
        if (div_done) begin
            div_done = 1'b0;
            div_busy = 1'b0;
        end else if (div_busy) begin
            model_cnt = model_cnt - 1;
            if (model_cnt == 0) begin
                div_done = 1'b1;
                div_quot = model_q;
            end
        end else if (div_cmd && !hang) begin
            div_busy  = 1'b1;
            model_cnt = QW;
            model_q   = (div_divisor == '0) ? '1 : div_dividend / {8'd0, div_divisor};
        end
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; that cycle is cycle 0. Returns the cycle numbers of the first cmd and of the ack.
    task automatic applyStimulus(input int idx, input logic [DW-1:0] dd, input logic [VW-1:0] dv,
                                 output int ack_cyc, output int cmd_cyc, output logic [NR-1:0] ack_v,
                                 output logic [QW-1:0] q_v, output logic d0_v, output logic err_v);
        dividend[idx*DW +: DW] = dd;
        divisor[idx*VW +: VW]  = dv;
        req[idx] = 1'b1;
        ack_cyc = -1;
        cmd_cyc = 0;
        ack_v = '0;
        q_v = '0;
        d0_v = 1'b0;
        err_v = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (div_cmd && cmd_cyc == 0) cmd_cyc = n;
            if (ack != '0) begin
                ack_cyc = n;
                ack_v = ack;
                q_v = quotient;
                d0_v = div0;
                err_v = err;
                req[idx] = 1'b0;
                break;
            end
        end
    endtask

    task automatic collectGrants(input int count, input bit reraise);
        logic [NR-1:0] raise_next;
        raise_next = '0;
        grants_got = 0;
        for (int n = 0; n < 1000 && grants_got < count; n++) begin
            @(negedge clk);
            req = req | raise_next;
            raise_next = '0;
            if (ack != '0) begin
                checkOutput("onehot_ack", $countones(ack), 1);
                for (int b = 0; b < NR; b++)
                    if (ack[b]) grant_order[grants_got] = b;
                grant_quot[grants_got] = quotient;
                grants_got++;
                req = req & ~ack;
                if (reraise) raise_next = ack;
            end
        end
        checkOutput("grant_count", grants_got, count);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int            ack_cyc;
        int            cmd_cyc;
        logic [NR-1:0] ack_v;
        logic [QW-1:0] q_v;
        logic          d0_v;
        logic          err_v;
        logic [NR-1:0] seen;

        vecs[0] = '{0, 16'd1000,  8'd7,   16'd142,   1'b0, 20, 2};
        vecs[1] = '{2, 16'd5,     8'd0,   16'hFFFF,  1'b1, 2,  0};
        vecs[2] = '{3, 16'd65535, 8'd255, 16'd257,   1'b0, 20, 2};
        vecs[3] = '{1, 16'd12345, 8'd1,   16'd12345, 1'b0, 20, 2};
        vecs[4] = '{1, 16'd7,     8'd200, 16'd0,     1'b0, 20, 2};
        vecs[5] = '{3, 16'd0,     8'd0,   16'hFFFF,  1'b1, 2,  0};
        vecs[6] = '{0, 16'd40000, 8'd3,   16'd13333, 1'b0, 20, 2};

        repeat (3) @(negedge clk);
        checkOutput("rst_ack", ack, 0);
        checkOutput("rst_quotient", quotient, 0);
        checkOutput("rst_div0", div0, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_cmd", div_cmd, 0);
        checkOutput("rst_dividend", div_dividend, 0);
        checkOutput("rst_divisor", div_divisor, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].idx, vecs[i].dd, vecs[i].dv, ack_cyc, cmd_cyc, ack_v, q_v, d0_v, err_v);
            checkOutput("vec_ack_cycle", ack_cyc, vecs[i].exp_ack);
            checkOutput("vec_cmd_cycle", cmd_cyc, vecs[i].exp_cmd);
            checkOutput("vec_ack_bits", ack_v, 1 << vecs[i].idx);
            checkOutput("vec_quotient", q_v, vecs[i].exp_q);
            checkOutput("vec_div0", d0_v, vecs[i].exp_div0);
            checkOutput("vec_err", err_v, 0);
            @(negedge clk);
            checkOutput("vec_ack_clear", ack, 0);
            checkOutput("vec_div0_clear", div0, 0);
            checkOutput("vec_quotient_hold", quotient, vecs[i].exp_q);
        end

        // Round robin from reset: all four requesting, then 0 and 2 again.
        doReset();
        dividend = {16'd400, 16'd300, 16'd200, 16'd100};
        divisor  = {8'd3, 8'd7, 8'd0, 8'd10};
        req = 4'b1111;
        collectGrants(4, 1'b0);
        for (int i = 0; i < 4; i++) checkOutput("rr_order", grant_order[i], i);
        checkOutput("rr_q0", grant_quot[0], 10);
        checkOutput("rr_q1", grant_quot[1], 16'hFFFF);
        checkOutput("rr_q2", grant_quot[2], 42);
        checkOutput("rr_q3", grant_quot[3], 133);
        req = 4'b0101;
        collectGrants(2, 1'b0);
        checkOutput("rr2_first", grant_order[0], 0);
        checkOutput("rr2_second", grant_order[1], 2);

        // Fairness: 1 and 3 keep re-requesting.
        doReset();
        dividend = {16'd9, 16'd0, 16'd100, 16'd0};
        divisor  = {8'd0, 8'd0, 8'd10, 8'd0};
        req = 4'b1010;
        collectGrants(6, 1'b1);
        req = '0;
        for (int i = 0; i < 6; i++) begin
            checkOutput("fair_order", grant_order[i], (i % 2 == 0) ? 1 : 3);
            checkOutput("fair_quot", grant_quot[i], (i % 2 == 0) ? 10 : 16'hFFFF);
        end
        @(negedge clk);

        // Hung divider: watchdog expiry, then normal service resumes.
        hang = 1'b1;
        applyStimulus(2, 16'd50, 8'd5, ack_cyc, cmd_cyc, ack_v, q_v, d0_v, err_v);
        checkOutput("hang_ack_cycle", ack_cyc, (1 << TW) - 1 + 4);
        checkOutput("hang_cmd_cycle", cmd_cyc, 2);
        checkOutput("hang_ack_bits", ack_v, 4'b0100);
        checkOutput("hang_err", err_v, 1);
        checkOutput("hang_quotient", q_v, 0);
        checkOutput("hang_div0", d0_v, 0);
        @(negedge clk);
        checkOutput("hang_err_clear", err, 0);
        hang = 1'b0;
        applyStimulus(2, 16'd50, 8'd5, ack_cyc, cmd_cyc, ack_v, q_v, d0_v, err_v);
        checkOutput("after_hang_ack_cycle", ack_cyc, 20);
        checkOutput("after_hang_quotient", q_v, 10);
        checkOutput("after_hang_err", err_v, 0);
        @(negedge clk);

        // Reset mid-WAIT: divider stays busy and later emits a stale done.
        doReset();
        dividend[0 +: DW] = 16'd1000;
        divisor[0 +: VW]  = 8'd7;
        req = 4'b0001;
        seen = '0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | ack;
        end
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        seen = seen | ack;
        rst = 1'b0;
        checkOutput("midrst_no_ack", seen, 0);
        checkOutput("midrst_cmd", div_cmd, 0);
        checkOutput("midrst_dividend", div_dividend, 0);
        applyStimulus(1, 16'd300, 8'd3, ack_cyc, cmd_cyc, ack_v, q_v, d0_v, err_v);
        checkOutput("midrst_cmd_cycle", cmd_cyc, 11);
        checkOutput("midrst_ack_cycle", ack_cyc, 29);
        checkOutput("midrst_ack_bits", ack_v, 4'b0010);
        checkOutput("midrst_quotient", q_v, 100);
        checkOutput("midrst_err", err_v, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got simulation still running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
